// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared W-bit register.
// Each write is a two-cycle grant/commit handshake; the granted requester may abort by dropping req.
module dff_write_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] d_in,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic [1:0]     last_id,
  output logic [7:0]     wr_cnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  elig_c;
  logic          sel_valid_c;
  logic [IW-1:0] sel_idx_c;
  logic [IW-1:0] cand_c;

  // Round-robin pick starting at ptr; a requester whose ack is high this cycle is masked.
  // Scanning from the far end lets the nearest eligible candidate win.
  always_comb begin
    elig_c      = req & ~ack;
    sel_valid_c = 1'b0;
    sel_idx_c   = '0;
    cand_c      = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand_c = IW'((32'(ptr) + 32'(k)) % N);
      if (elig_c[cand_c]) begin
        sel_valid_c = 1'b1;
        sel_idx_c   = cand_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      grant   <= '0;
      ack     <= '0;
      q       <= '0;
      busy    <= 1'b0;
      last_id <= '0;
      wr_cnt  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (sel_valid_c) begin
            state            <= BUSY;
            busy             <= 1'b1;
            gnt_idx          <= sel_idx_c;
            grant            <= '0;
            grant[sel_idx_c] <= 1'b1;
          end
        end
        BUSY: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
          // Commit only if the granted requester still holds its request.
          if (req[gnt_idx]) begin
            q       <= d_in[32'(gnt_idx)*W +: W];
            ack     <= grant;
            last_id <= 2'(gnt_idx);
            wr_cnt  <= wr_cnt + 8'd1;
            ptr     <= IW'((32'(gnt_idx) + 32'd1) % N);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Self-checking bench for dff_write_arbiter: scenario tasks plus a scoreboard of expected writes.
module tb_dff_write_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] d_in = '0;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   q;
  logic           busy;
  logic [1:0]     last_id;
  logic [7:0]     wr_cnt;

  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_cnt = '0;
  exp_t sb[$];

  dff_write_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .d_in(d_in), .grant(grant), .ack(ack),
    .q(q), .busy(busy), .last_id(last_id), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected write on every ack and checks the committed state.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) exp_cnt = '0;
      checks++; if ($countones(grant) > 1) begin errors++; $display("FAIL grant_onehot: got %b want at most one bit", grant); end
      checks++; if ($countones(ack) > 1) begin errors++; $display("FAIL ack_onehot: got %b want at most one bit", ack); end
      if (ack !== '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %b want 0000", ack);
        end else begin
          e = sb.pop_front();
          exp_cnt = exp_cnt + 8'd1;
          checks++; if (ack !== 4'(4'b0001 << e.id)) begin errors++; $display("FAIL ack_id: got %b want id %0d", ack, e.id); end
          checks++; if (q !== e.data) begin errors++; $display("FAIL q_data: got %h want %h", q, e.data); end
          checks++; if (last_id !== e.id) begin errors++; $display("FAIL last_id: got %0d want %0d", last_id, e.id); end
          checks++; if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL wr_cnt: got %0d want %0d", wr_cnt, exp_cnt); end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL rst_ack: got %b want 0000", ack); end
    checks++; if (q !== '0) begin errors++; $display("FAIL rst_q: got %h want 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (last_id !== '0) begin errors++; $display("FAIL rst_last_id: got %0d want 0", last_id); end
    checks++; if (wr_cnt !== '0) begin errors++; $display("FAIL rst_wr_cnt: got %0d want 0", wr_cnt); end
  endtask

  task automatic test_single();
    exp_t e;
    d_in[0*W +: W] = 8'hA5;
    req = 4'b0001;
    e.id = 2'd0; e.data = 8'hA5; sb.push_back(e);
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_clear: got %b want 0000", grant); end
    req = '0;
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    d_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      e.id = 2'(k % 4);
      e.data = d_in[(k % 4)*W +: W];
      sb.push_back(e);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (grant !== 4'(4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant, 4'(4'b0001 << (k % 4))); end
      step();
    end
    req = '0;
    step();
    checks++; if (grant !== '0) begin errors++; $display("FAIL rr_idle_grant: got %b want 0000", grant); end
  endtask

  task automatic test_abort();
    exp_t e;
    d_in[2*W +: W] = 8'h77;
    req = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL abort_grant: got %b want 0100", grant); end
    req = '0;
    step();
    checks++; if (ack !== '0) begin errors++; $display("FAIL abort_ack: got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (q !== 8'h11) begin errors++; $display("FAIL abort_q: got %h want 11", q); end
    checks++; if (wr_cnt !== 8'd5) begin errors++; $display("FAIL abort_wr_cnt: got %0d want 5", wr_cnt); end
    checks++; if (last_id !== 2'd0) begin errors++; $display("FAIL abort_last_id: got %0d want 0", last_id); end
    // Pointer must still be 1, so requester 1 wins over 2 and 3.
    req = 4'b1110;
    e.id = 2'd1; e.data = 8'h22; sb.push_back(e);
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_ptr_grant: got %b want 0010", grant); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_mask();
    exp_t e;
    req = 4'b0010;
    e.id = 2'd1; e.data = 8'h22;
    sb.push_back(e);
    sb.push_back(e);
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mask_grant1: got %b want 0010", grant); end
    step();
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mask_no_regrant: got %b want 0000", grant); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mask_regrant: got %b want 0010", grant); end
    step();
    req = '0;
    step();
  endtask

  task automatic test_reset_busy();
    d_in[0*W +: W] = 8'h3C;
    req = 4'b0001;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b want 1", busy); end
    rst = 1'b0;
    step();
    checks++; if (grant !== '0) begin errors++; $display("FAIL rb_grant: got %b want 0000", grant); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL rb_ack: got %b want 0000", ack); end
    checks++; if (q !== '0) begin errors++; $display("FAIL rb_q: got %h want 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rb_busy_clr: got %b want 0", busy); end
    checks++; if (last_id !== '0) begin errors++; $display("FAIL rb_last_id: got %0d want 0", last_id); end
    checks++; if (wr_cnt !== '0) begin errors++; $display("FAIL rb_wr_cnt: got %0d want 0", wr_cnt); end
    rst = 1'b1;
    req = '0;
    step();
    checks++; if (ack !== '0) begin errors++; $display("FAIL rb_no_ack: got %b want 0000", ack); end
    checks++; if (q !== '0) begin errors++; $display("FAIL rb_q_after: got %h want 00", q); end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   wcount;
    do_reset();
    for (int i = 0; i < 4; i++) d_in[i*W +: W] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 256; k++) begin
      e.id = 2'(k % 4);
      e.data = d_in[(k % 4)*W +: W];
      sb.push_back(e);
    end
    req = 4'b1111;
    wcount = 0;
    for (int s = 0; s < 700 && wcount < 256; s++) begin
      step();
      if (ack !== '0) begin
        wcount++;
        if (wcount == 255) begin
          checks++; if (wr_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", wr_cnt); end
        end
      end
    end
    req = '0;
    checks++; if (wcount != 256) begin errors++; $display("FAIL wrap_timeout: got %0d writes want 256", wcount); end
    checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", wr_cnt); end
    checks++; if (q !== d_in[3*W +: W]) begin errors++; $display("FAIL wrap_q: got %h want %h", q, d_in[3*W +: W]); end
    checks++; if (last_id !== 2'd3) begin errors++; $display("FAIL wrap_last_id: got %0d want 3", last_id); end
    step();
    step();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_mask();
    test_reset_busy();
    test_wrap();
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
